fifo_nibble_tx: RTL

FIFO_NIBBLE_TX -- requirements
Module: fifo_nibble_tx

---
 rtl/fifo_nibble_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_nibble_tx.sv
// rtl/fifo_nibble_tx.sv - drains 4-bit FIFO words into framed serial output with optional even parity
module fifo_nibble_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE, POP, LOAD, START, DATA, PARITY, STOP
    } state_t;

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_nx;
    logic [7:0] baud, baud_nx;
    logic [1:0] bit_idx, bit_idx_nx;
    logic [3:0] shreg, shreg_nx;
    logic       parity, parity_nx;
    logic       tx_nx, fifo_rd_nx, busy_nx, frame_done_nx;
    logic       bit_end;

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            baud       <= 8'd0;
            bit_idx    <= 2'd0;
            shreg      <= 4'd0;
            parity     <= 1'b0;
            tx         <= 1'b1;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            baud       <= baud_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            parity     <= parity_nx;
            tx         <= tx_nx;
            fifo_rd    <= fifo_rd_nx;
            busy       <= busy_nx;
            frame_done <= frame_done_nx;
        end
    end

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_nx   = state;
        baud_nx    = 8'd0;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        parity_nx  = parity;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) state_nx = POP;
            end
            POP: state_nx = LOAD;
            LOAD: begin
                state_nx  = START;
                shreg_nx  = fifo_data;
                parity_nx = ^fifo_data;
            end
            START: begin
                baud_nx = bit_end ? 8'd0 : baud + 8'd1;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                baud_nx = bit_end ? 8'd0 : baud + 8'd1;
                if (bit_end) begin
                    // shift so the next data bit always sits in shreg[0]
                    bit_idx_nx = bit_idx + 2'd1;
                    shreg_nx   = {1'b0, shreg[3:1]};
                    if (bit_idx == 2'd3) state_nx = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                baud_nx = bit_end ? 8'd0 : baud + 8'd1;
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                baud_nx = bit_end ? 8'd0 : baud + 8'd1;
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs are decoded from the next state so the registered copies line up with the state
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
            PARITY:  tx_nx = parity_nx;
            default: tx_nx = 1'b1;
        endcase
        fifo_rd_nx    = (state_nx == POP);
        busy_nx       = (state_nx != IDLE);
        frame_done_nx = (state_nx == STOP) && (baud_nx == BAUD_LAST);
    end

endmodule
